// File: rtl/inst_fetch_req_ctrl_pkg.sv
// Shared definitions for the instruction-fetch request controller.
//   ADDR_W / DATA_W : fetch address and packet widths
//   MAX_OUT         : outstanding address-accepted request limit
//   Ce*             : 2-bit rdata-cancel codes sent to the IF-side cancel FSM
//   sat_cnt         : clamps a 3-bit intermediate count into a 2-bit counter
package inst_fetch_req_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 2;

  localparam logic [1:0] MaxOut2 = 2'(MAX_OUT);
  localparam logic [2:0] MaxOut3 = 3'(MAX_OUT);

  localparam logic [1:0] CeMark = 2'b10;
  localparam logic [1:0] CeUse  = 2'b01;
  localparam logic [1:0] CeIdle = 2'b00;

  function automatic logic [1:0] sat_cnt(input logic [2:0] v);
    return (v > MaxOut3) ? MaxOut2 : v[1:0];
  endfunction

endpackage

// File: rtl/fetch_cancel_code_gen.sv
// Cancel-code generator: accumulates pending "mark" and "consumed" events and
// emits one code per cycle, marks first, so every 01 follows its 10.
//   clk, rst_n   : clock, async active-low reset
//   i_mark_add   : number of responses newly marked cancelled this cycle
//   i_use_inc    : a cancelled response was consumed this cycle
//   o_ce_we      : registered code (10 mark, 01 consumed, 00 idle)
module fetch_cancel_code_gen
  import inst_fetch_req_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_mark_add,
  input  logic       i_use_inc,
  output logic [1:0] o_ce_we
);

  logic [1:0] r_mark_pend;
  logic [1:0] r_use_pend;
  logic [1:0] r_ce_we;
  logic [2:0] w_mark_eff;
  logic [2:0] w_use_eff;

  // Fold this cycle's events in so the code appears one cycle after its cause.
  assign w_mark_eff = {1'b0, r_mark_pend} + {1'b0, i_mark_add};
  assign w_use_eff  = {1'b0, r_use_pend} + {2'b00, i_use_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mark_pend <= 2'd0;
      r_use_pend  <= 2'd0;
      r_ce_we     <= CeIdle;
    end else if (w_mark_eff != 3'd0) begin
      r_ce_we     <= CeMark;
      r_mark_pend <= sat_cnt(w_mark_eff - 3'd1);
      r_use_pend  <= sat_cnt(w_use_eff);
    end else if (w_use_eff != 3'd0) begin
      r_ce_we     <= CeUse;
      r_mark_pend <= 2'd0;
      r_use_pend  <= sat_cnt(w_use_eff - 3'd1);
    end else begin
      r_ce_we     <= CeIdle;
      r_mark_pend <= 2'd0;
      r_use_pend  <= 2'd0;
    end
  end

  assign o_ce_we = r_ce_we;

endmodule

// File: rtl/inst_fetch_req_ctrl.sv
// Instruction-fetch bus sequencer between pre-IF and IF.
//   preif_req_i/preif_addr_i/preif_ready_o : pre-IF request and handshake
//   excep_flush_i/banch_flush_i            : flush sources
//   inst_sram_*                            : SRAM-like instruction bus
//   if_allowin_i/if_data_ok_o/if_rdata_o   : packet delivery to IF
//   inst_rdata_ce_we_o                     : cancel code for the IF cancel FSM
//   inst_rdata_buffer_o                    : {buf_valid, buf_data}
// At most one live packet is in flight; older cancelled responses may still
// be outstanding and are discarded in order as they return.
module inst_fetch_req_ctrl
  import inst_fetch_req_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              preif_req_i,
  input  logic [ADDR_W-1:0] preif_addr_i,
  input  logic              excep_flush_i,
  input  logic              banch_flush_i,
  input  logic              if_allowin_i,
  output logic              inst_sram_req_o,
  output logic [ADDR_W-1:0] inst_sram_addr_o,
  input  logic              inst_sram_addr_ok_i,
  input  logic              inst_sram_data_ok_i,
  input  logic [DATA_W-1:0] inst_sram_rdata_i,
  output logic              preif_ready_o,
  output logic [1:0]        inst_rdata_ce_we_o,
  output logic [DATA_W:0]   inst_rdata_buffer_o,
  output logic              if_data_ok_o,
  output logic [DATA_W-1:0] if_rdata_o
);

  logic [1:0]        r_out_cnt;
  logic [1:0]        r_cancel_cnt;
  logic              r_buf_valid;
  logic [DATA_W-1:0] r_buf_data;

  logic       w_flush;
  logic [1:0] w_live;
  logic       w_req;
  logic       w_hs;
  logic       w_dok;
  logic       w_live_dok;
  logic       w_canc_dok;
  logic [1:0] w_out_next;
  logic [1:0] w_cancel_next;
  logic [1:0] w_mark_add;

  assign w_flush = excep_flush_i | banch_flush_i;
  assign w_live  = r_out_cnt - r_cancel_cnt;

  // Gated by rst_n so every output drops the moment reset asserts.
  assign w_req = rst_n & preif_req_i & ~w_flush & (r_out_cnt < MaxOut2)
               & (w_live == 2'd0) & ~r_buf_valid;
  assign w_hs  = w_req & inst_sram_addr_ok_i;

  // A response with nothing outstanding is ignored rather than underflowing.
  assign w_dok      = rst_n & inst_sram_data_ok_i & (r_out_cnt != 2'd0);
  assign w_live_dok = w_dok & ~w_flush & (r_cancel_cnt == 2'd0);
  assign w_canc_dok = w_dok & ~w_flush & (r_cancel_cnt != 2'd0);

  always_comb begin
    w_out_next = r_out_cnt;
    if (w_hs && !w_dok && (r_out_cnt < MaxOut2)) begin
      w_out_next = r_out_cnt + 2'd1;
    end else if (!w_hs && w_dok) begin
      w_out_next = r_out_cnt - 2'd1;
    end
  end

  // On flush everything still outstanding (minus a response landing now,
  // which is dropped) becomes cancelled; only growth is reported as marks.
  always_comb begin
    w_cancel_next = r_cancel_cnt;
    w_mark_add    = 2'd0;
    if (w_flush) begin
      w_cancel_next = r_out_cnt - {1'b0, w_dok};
      if (w_cancel_next > r_cancel_cnt) begin
        w_mark_add = w_cancel_next - r_cancel_cnt;
      end
    end else if (w_canc_dok) begin
      w_cancel_next = r_cancel_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt    <= 2'd0;
      r_cancel_cnt <= 2'd0;
    end else begin
      r_out_cnt    <= w_out_next;
      r_cancel_cnt <= w_cancel_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (w_flush || (r_buf_valid && if_allowin_i)) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else if (w_live_dok && !if_allowin_i) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= inst_sram_rdata_i;
    end
  end

  fetch_cancel_code_gen u_ce_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_mark_add (w_mark_add),
    .i_use_inc  (w_canc_dok),
    .o_ce_we    (inst_rdata_ce_we_o)
  );

  assign inst_sram_req_o     = w_req;
  assign inst_sram_addr_o    = preif_addr_i;
  assign preif_ready_o       = w_hs;
  assign if_data_ok_o        = r_buf_valid | w_live_dok;
  assign if_rdata_o          = r_buf_valid ? r_buf_data : inst_sram_rdata_i;
  assign inst_rdata_buffer_o = {r_buf_valid, r_buf_data};

endmodule

// File: tb/tb_inst_fetch_req_ctrl.sv
module tb_inst_fetch_req_ctrl;
  import inst_fetch_req_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              preif_req_i = 1'b0;
  logic [ADDR_W-1:0] preif_addr_i = '0;
  logic              excep_flush_i = 1'b0;
  logic              banch_flush_i = 1'b0;
  logic              if_allowin_i = 1'b0;
  logic              inst_sram_req_o;
  logic [ADDR_W-1:0] inst_sram_addr_o;
  logic              inst_sram_addr_ok_i = 1'b0;
  logic              inst_sram_data_ok_i = 1'b0;
  logic [DATA_W-1:0] inst_sram_rdata_i = '0;
  logic              preif_ready_o;
  logic [1:0]        inst_rdata_ce_we_o;
  logic [DATA_W:0]   inst_rdata_buffer_o;
  logic              if_data_ok_o;
  logic [DATA_W-1:0] if_rdata_o;

  inst_fetch_req_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .preif_req_i         (preif_req_i),
    .preif_addr_i        (preif_addr_i),
    .excep_flush_i       (excep_flush_i),
    .banch_flush_i       (banch_flush_i),
    .if_allowin_i        (if_allowin_i),
    .inst_sram_req_o     (inst_sram_req_o),
    .inst_sram_addr_o    (inst_sram_addr_o),
    .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
    .inst_sram_data_ok_i (inst_sram_data_ok_i),
    .inst_sram_rdata_i   (inst_sram_rdata_i),
    .preif_ready_o       (preif_ready_o),
    .inst_rdata_ce_we_o  (inst_rdata_ce_we_o),
    .inst_rdata_buffer_o (inst_rdata_buffer_o),
    .if_data_ok_o        (if_data_ok_o),
    .if_rdata_o          (if_rdata_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of outstanding transactions in return order,
  // 1 = cancelled. Pending code counts and the IF-side hold buffer.
  bit          q[$];
  int          mark_p, use_p;
  logic [1:0]  exp_ce;
  bit          buf_v;
  logic [63:0] buf_d;
  logic [31:0] cur_addr;
  int          marks_seen, uses_seen;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mark_p = 0; use_p = 0; exp_ce = 2'b00;
    buf_v = 1'b0; buf_d = '0;
  endtask

  task automatic check_and_step(input bit preq, input bit fl, input bit allow,
                                input bit aok, input bit dk, input logic [63:0] rd);
    int nc, old_c, new_c, madd, em, eu;
    bit ereq, hs, dk_eff, front_c, ldok, uinc, c;
    nc = 0;
    foreach (q[i]) if (q[i]) nc++;
    ereq    = preq && !fl && (q.size() < MAX_OUT) && (q.size() == nc) && !buf_v;
    hs      = ereq && aok;
    dk_eff  = dk && (q.size() > 0);
    front_c = (q.size() > 0) ? q[0] : 1'b0;
    ldok    = dk_eff && !fl && !front_c;

    chk("req", inst_sram_req_o, ereq);
    chk("addr", inst_sram_addr_o, cur_addr);
    chk("ready", preif_ready_o, hs);
    chk("data_ok", if_data_ok_o, buf_v || ldok);
    if (buf_v || ldok) chk("rdata", if_rdata_o, buf_v ? buf_d : rd);
    chk("ce_we", inst_rdata_ce_we_o, exp_ce);
    chk("buffer", inst_rdata_buffer_o, {buf_v, buf_d});
    if (ldok) chk("live_dok_with_buf", buf_v, 1'b0);
    if (inst_rdata_ce_we_o == 2'b10) marks_seen++;
    if (inst_rdata_ce_we_o == 2'b01) uses_seen++;
    chk("ce_order", uses_seen <= marks_seen, 1'b1);

    madd = 0; uinc = 0;
    if (fl) begin
      old_c = nc;
      if (dk_eff) c = q.pop_front();
      new_c = q.size();
      foreach (q[i]) q[i] = 1'b1;
      if (new_c > old_c) madd = new_c - old_c;
      buf_v = 1'b0; buf_d = '0;
    end else begin
      if (buf_v && allow) begin buf_v = 1'b0; buf_d = '0; end
      if (dk_eff) begin
        c = q.pop_front();
        if (c) uinc = 1;
        else if (!allow) begin buf_v = 1'b1; buf_d = rd; end
      end
    end
    if (hs) begin
      q.push_back(1'b0);
      cur_addr = $urandom;
    end

    em = mark_p + madd;
    eu = use_p + uinc;
    if (em > 0) begin
      exp_ce = 2'b10; mark_p = em - 1; use_p = eu;
    end else if (eu > 0) begin
      exp_ce = 2'b01; use_p = eu - 1;
    end else begin
      exp_ce = 2'b00;
    end
    chk("outstanding_max", q.size() <= MAX_OUT, 1'b1);
    chk("pend_max", (mark_p <= MAX_OUT) && (use_p <= MAX_OUT), 1'b1);
  endtask

  task automatic cyc(input bit preq, input bit fe, input bit fb, input bit allow,
                     input bit aok, input bit dk, input logic [63:0] rd);
    @(posedge clk); #1;
    preif_req_i = preq; excep_flush_i = fe; banch_flush_i = fb;
    if_allowin_i = allow; inst_sram_addr_ok_i = aok;
    inst_sram_data_ok_i = dk; inst_sram_rdata_i = rd; preif_addr_i = cur_addr;
    @(negedge clk);
    check_and_step(preq, fe | fb, allow, aok, dk, rd);
  endtask

  // Asserts reset away from any clock edge and checks outputs fall at once.
  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_req", inst_sram_req_o, 1'b0);
    chk("rst_ready", preif_ready_o, 1'b0);
    chk("rst_ce", inst_rdata_ce_we_o, 2'b00);
    chk("rst_buf", inst_rdata_buffer_o, '0);
    chk("rst_dok", if_data_ok_o, 1'b0);
    model_reset();
    preif_req_i = 1'b0; excep_flush_i = 1'b0; banch_flush_i = 1'b0;
    if_allowin_i = 1'b0; inst_sram_addr_ok_i = 1'b0; inst_sram_data_ok_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    marks_seen = 0; uses_seen = 0;
    cur_addr = 32'h1C00_0000;
    preif_addr_i = cur_addr;
    preif_req_i = 1'b1;
    inst_sram_data_ok_i = 1'b1;
    #2;
    chk("por_req", inst_sram_req_o, 1'b0);
    chk("por_dok", if_data_ok_o, 1'b0);
    chk("por_buf", inst_rdata_buffer_o, '0);
    async_reset();

    // First issue: addr_ok on the third requesting cycle.
    cyc(1, 0, 0, 1, 0, 0, '0);
    cyc(1, 0, 0, 1, 0, 0, '0);
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, '0);
    // Live response delivered straight through.
    cyc(0, 0, 0, 1, 0, 1, 64'h0280_0001_0280_0002);
    // Live response held in the buffer while IF stalls.
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(1, 0, 0, 0, 0, 1, 64'h0280_0003_0280_0004);
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 0, '0);
    // Branch flush with one outstanding; response returns 4 cycles later.
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(0, 0, 1, 1, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 1, 64'hDEAD_BEEF_0000_0001);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);
    // Cancelled straggler plus live, flushed; response right after flush.
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(0, 1, 0, 1, 0, 0, '0);
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(0, 0, 1, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 1, 64'h1111_2222_3333_4444);
    cyc(0, 0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, 1, 64'h5555_6666_7777_8888);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, '0);
    // Flush coincident with a response, then reset mid-burst.
    cyc(1, 0, 0, 1, 1, 0, '0);
    cyc(0, 1, 0, 1, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);
    cyc(1, 0, 0, 1, 1, 0, '0);
    preif_req_i = 1'b1;
    inst_sram_data_ok_i = 1'b1;
    async_reset();

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      cyc(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 16) == 0,
          ($urandom % 3) != 0, ($urandom % 2) == 1,
          (q.size() > 0) && (($urandom % 3) == 0), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
